// File: rtl/reg_wb_scheduler_pkg.sv
// Shared sizing constants and FSM encoding for the register writeback scheduler.
package reg_wb_scheduler_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/reg_wb_scheduler_if.sv
// Issue, writeback, register-file and control signals of the scheduler.
interface reg_wb_scheduler_if #(
  parameter int unsigned NREG = reg_wb_scheduler_pkg::NREG
);
  import reg_wb_scheduler_pkg::*;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rd_we;
  logic              stall_flag;

  logic              alu_wb_valid;
  logic [ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;
  logic              alu_wb_ready;
  logic              mem_wb_valid;
  logic [ADDR_W-1:0] mem_wb_addr;
  logic [DATA_W-1:0] mem_wb_data;
  logic              mem_wb_ready;

  logic              reg_wr;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;

  logic              drain_req;
  logic              drain_done;
  logic              flush;
  logic [NREG-1:0]   busy_vec;
  logic              wb_err;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    output mem_wb_valid, mem_wb_addr, mem_wb_data,
    output drain_req, flush,
    input  stall_flag, alu_wb_ready, mem_wb_ready,
    input  reg_wr, reg_wr_addr, reg_wr_data,
    input  drain_done, busy_vec, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  mem_wb_valid, mem_wb_addr, mem_wb_data,
    input  drain_req, flush,
    output stall_flag, alu_wb_ready, mem_wb_ready,
    output reg_wr, reg_wr_addr, reg_wr_data,
    output drain_done, busy_vec, wb_err
  );

endinterface

// File: rtl/reg_wb_scheduler_rr_arb.sv
// Two-requester round-robin arbiter; priority flips to the other side after each grant.
module wb_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  logic prio_mem;

  // Grants are gated by reset so nothing is granted while reset is held.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (reset) begin
      if (req_alu && req_mem) begin
        gnt_alu = !prio_mem;
        gnt_mem = prio_mem;
      end else begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_mem <= 1'b0;
    end else if (gnt_alu) begin
      prio_mem <= 1'b1;
    end else if (gnt_mem) begin
      prio_mem <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register scoreboard: tracks pending writes per register, stalls hazards,
// arbitrates ALU/MEM writebacks onto the register-file write port.
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
#(
  parameter int unsigned NREG  = reg_wb_scheduler_pkg::NREG,
  parameter int unsigned CNT_W = reg_wb_scheduler_pkg::CNT_W
) (
  input logic               clk,
  input logic               reset,
  reg_wb_scheduler_if.slave bus
);

  logic [CNT_W-1:0]  pending [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_full;
  logic              wb_idle;
  logic              gnt_alu;
  logic              gnt_mem;
  logic              xfer;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              accept;
  logic              in_drain;
  logic              drain_done;
  logic              wb_err;
  state_t            state_q;
  state_t            state_d;

  wb_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (bus.alu_wb_valid),
    .req_mem (bus.mem_wb_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  assign xfer    = gnt_alu | gnt_mem;
  assign wb_addr = gnt_mem ? bus.mem_wb_addr : bus.alu_wb_addr;
  assign wb_data = gnt_mem ? bus.mem_wb_data : bus.alu_wb_data;

  // Register 0 is skipped: its slot stays zero so it never reads busy.
  always_comb begin
    busy     = '0;
    inc_vec  = '0;
    dec_vec  = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rd_full  = 1'b0;
    wb_idle  = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy[i]    = (pending[i] != '0);
      inc_vec[i] = accept && bus.iss_rd_we && (bus.iss_rd == ADDR_W'(i));
      dec_vec[i] = xfer && (wb_addr == ADDR_W'(i));
      if (bus.iss_rs1 == ADDR_W'(i)) rs1_busy = busy[i];
      if (bus.iss_rs2 == ADDR_W'(i)) rs2_busy = busy[i];
      if (bus.iss_rd_we && (bus.iss_rd == ADDR_W'(i))) rd_full = (pending[i] == '1);
      if (wb_addr == ADDR_W'(i)) wb_idle = (pending[i] == '0);
    end
  end

  assign in_drain       = (state_q == ST_DRAIN);
  assign bus.stall_flag = bus.iss_valid && (rs1_busy || rs2_busy || rd_full || in_drain);
  assign accept         = bus.iss_valid && !bus.stall_flag && !bus.flush;

  // Issue and writeback to the same register cancel; underflow holds at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) pending[i] <= '0;
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < NREG; i++) pending[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          pending[i] <= pending[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i] && (pending[i] != '0)) begin
          pending[i] <= pending[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.reg_wr      <= 1'b0;
      bus.reg_wr_addr <= '0;
      bus.reg_wr_data <= '0;
      wb_err          <= 1'b0;
    end else begin
      bus.reg_wr <= xfer && (wb_addr != '0);
      if (xfer && (wb_addr != '0)) begin
        bus.reg_wr_addr <= wb_addr;
        bus.reg_wr_data <= wb_data;
        if (wb_idle) wb_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_done = ~|busy;
        if (!bus.drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.alu_wb_ready = gnt_alu;
  assign bus.mem_wb_ready = gnt_mem;
  assign bus.busy_vec     = busy;
  assign bus.drain_done   = drain_done;
  assign bus.wb_err       = wb_err;

endmodule

// File: doc/reg_wb_scheduler.md
REG_WB_SCHEDULER -- requirements
Module: reg_wb_scheduler

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_W, default 2, meaning the pending-write counter width per register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port iss_valid, input, 1, decode presents an instruction.
REQ-006 SHALL have ports iss_rs1, iss_rs2, iss_rd, input, 5 each, source and destination register addresses.
REQ-007 SHALL have port iss_rd_we, input, 1, the instruction writes iss_rd.
REQ-008 SHALL have port stall_flag, output, 1, holds decode and register-file reads.
REQ-009 SHALL have ports alu_wb_valid / mem_wb_valid, input, 1 each, writeback requests.
REQ-010 SHALL have ports alu_wb_addr / mem_wb_addr, input, 5 each, and alu_wb_data / mem_wb_data, input, 32 each.
REQ-011 SHALL have ports alu_wb_ready / mem_wb_ready, output, 1 each, grant for the current cycle.
REQ-012 SHALL have ports reg_wr (output, 1), reg_wr_addr (output, 5) and reg_wr_data (output, 32), which drive the register-file write port.
REQ-013 SHALL have ports drain_req (input, 1) and drain_done (output, 1).
REQ-014 SHALL have ports flush (input, 1), busy_vec (output, NREG) and wb_err (output, 1).

Function
REQ-015 SHALL keep one CNT_W-bit pending counter per register; busy_vec[i] = (pending[i] != 0); register 0 is never tracked and always reads 0.
REQ-016 stall_flag SHALL be combinational and equal iss_valid AND (any of the following, or state == DRAIN):
- rs1 != 0 and busy;
- rs2 != 0 and busy;
- (iss_rd_we, rd != 0, pending[rd] == max).
REQ-017 An issue SHALL be accepted when iss_valid && !stall_flag; an accepted issue with iss_rd_we and rd != 0 increments pending[rd].
REQ-018 SHALL grant at most one writeback per cycle:
- when only one requester is valid, it is granted;
- when both are valid, round-robin alternates starting from ALU after reset.
REQ-019 ready SHALL be combinational and equal to the grant; a transfer occurs when valid && ready, and requesters hold addr/data until the transfer.
REQ-020 A transfer SHALL decrement pending[addr] at the same edge, and SHALL register reg_wr = 1, reg_wr_addr and reg_wr_data for exactly the next cycle (1-cycle latency).
REQ-021 A transfer with addr 0 SHALL be accepted, SHALL NOT assert reg_wr, and SHALL NOT change any counter.
REQ-022 A transfer to a register whose pending count is 0 SHALL still write, leave the count at 0, and set wb_err sticky until reset.
REQ-023 An accepted issue and a transfer to the same register in the same cycle SHALL leave the count unchanged.
REQ-024 flush SHALL clear all counters at the next edge; a same-cycle transfer SHALL still write, and a same-cycle issue SHALL be dropped.
REQ-025 The FSM SHALL have states RUN and DRAIN, plus a DONE indication, with these transitions:
- RUN -> DRAIN on drain_req;
- in DRAIN, drain_done = 1 whenever all counters are 0;
- DRAIN -> RUN when drain_req deasserts.
REQ-026 Writebacks SHALL continue to be granted in DRAIN.

Reset
REQ-027 On reset low, asynchronously:
- counters 0, stall_flag 0 (iss_valid permitting), ready 0;
- reg_wr 0, reg_wr_addr 0, reg_wr_data 0;
- drain_done 0, wb_err 0, FSM RUN, round-robin pointer ALU.
REQ-028 Reset asserted mid-operation SHALL discard in-flight grants; requesters re-present after release.

Structure
REQ-029 A shared package SHALL hold NREG, CNT_W, the register address width (5), the data width (32), and the FSM state encoding.
REQ-030 The two-requester round-robin arbiter SHALL be one sub-module, wb_rr_arb.

Verification
REQ-031 Issue rd=5 then rs1=5 next cycle -> stall_flag = 1 until the ALU transfers addr 5; stall_flag = 0 in the cycle reg_wr = 1, addr 5.
REQ-032 ALU and MEM both valid for 4 cycles -> grants ALU, MEM, ALU, MEM; reg_wr pulses on 4 consecutive cycles with the matching data.
REQ-033 Three issues to rd=7 -> pending[7] = 3, and a fourth issue to rd=7 stalls; one transfer to 7 releases it.
REQ-034 MEM transfer to addr 0 with data 0xDEADBEEF -> mem_wb_ready = 1, reg_wr stays 0; a transfer to idle r9 -> reg_wr = 1 and wb_err = 1.
REQ-035 drain_req with r4 and r15 pending -> issues stall; drain_done = 1 after both transfers; RUN after drain_req falls.
REQ-036 reset low mid-grant -> all outputs 0 immediately; flush with pending[16] = 2 -> busy_vec = 0 next cycle.
